// File: rtl/bullet_pkg.sv
// rtl/bullet_pkg.sv - shared types and width helpers for the bullet slot arbiter
package bullet_pkg;

    typedef enum logic {
        PLAYER_1 = 1'b0,
        PLAYER_2 = 1'b1
    } player_e;

    // Width of the cooldown frame counter; holds any load value up to 255.
    localparam int COOLDOWN_W = 8;

    // Bits needed to index one of n slots.
    function automatic int slot_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed to count 0..n occupied slots.
    function automatic int slot_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/press_latch.sv
// rtl/press_latch.sv - shoot button edge detector with a pending request flag
//
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   shoot      : raw level of the shoot button
//   tick       : frame tick; the arbitration point that consumes the request
//   keep       : hold the pending flag across this tick (lost a contention)
//   pending    : a request is waiting for the next tick
module press_latch (
    input  logic clk,
    input  logic reset,
    input  logic shoot,
    input  logic tick,
    input  logic keep,
    output logic pending
);

    logic shoot_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            shoot_q <= 1'b0;
            pending <= 1'b0;
        end else begin
            shoot_q <= shoot;
            // An edge landing on a tick is captured after that tick's
            // evaluation, so setting wins over the tick clear.
            if (shoot && !shoot_q) begin
                pending <= 1'b1;
            end else if (tick && !keep) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bullet_slot_arbiter.sv
// rtl/bullet_slot_arbiter.sv - shared bullet slot pool and two-player spawn arbiter
//
// Ports:
//   clk_i, reset_i            : VGA clock, synchronous active-high reset
//   player_1/2_shoot_i        : shoot button levels
//   frame_tick_i              : one-cycle frame pulse, the only arbitration point
//   slot_release_i            : per-slot release flags from the bullet engine
//   spawn_valid/player/slot_o : one-cycle spawn command, one cycle after the tick
//   slot_busy_o, slot_owner_o : occupancy and owner (0 = P1, 1 = P2) per slot
//   p1/p2_active_o            : active bullet count per player
//   p1/p2_cooling_o           : per-player cooldown still running
import bullet_pkg::*;

module bullet_slot_arbiter #(
    parameter int NUM_SLOTS       = 4,
    parameter int MAX_PER_PLAYER  = 2,
    parameter int COOLDOWN_FRAMES = 15
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 player_1_shoot_i,
    input  logic                                 player_2_shoot_i,
    input  logic                                 frame_tick_i,
    input  logic [NUM_SLOTS-1:0]                 slot_release_i,
    output logic                                 spawn_valid_o,
    output logic                                 spawn_player_o,
    output logic [slot_idx_w(NUM_SLOTS)-1:0]     spawn_slot_o,
    output logic [NUM_SLOTS-1:0]                 slot_busy_o,
    output logic [NUM_SLOTS-1:0]                 slot_owner_o,
    output logic [slot_cnt_w(NUM_SLOTS)-1:0]     p1_active_o,
    output logic [slot_cnt_w(NUM_SLOTS)-1:0]     p2_active_o,
    output logic                                 p1_cooling_o,
    output logic                                 p2_cooling_o
);

    localparam int IW = slot_idx_w(NUM_SLOTS);
    localparam int CW = slot_cnt_w(NUM_SLOTS);
    localparam logic [CW-1:0]         MAX_CNT = CW'(MAX_PER_PLAYER);
    localparam logic [COOLDOWN_W-1:0] CD_LOAD = COOLDOWN_W'(COOLDOWN_FRAMES);

    logic                  pend_1, pend_2;
    logic                  keep_1, keep_2;
    logic [COOLDOWN_W-1:0] cd_1, cd_2;
    player_e               prio;

    logic                  any_free;
    logic [IW-1:0]         free_idx;
    logic                  elig_1, elig_2, contend, grant;
    player_e               grant_player;
    logic [NUM_SLOTS-1:0]  grant_mask;
    logic [NUM_SLOTS-1:0]  rel_mask;
    logic [CW-1:0]         rel_cnt_1, rel_cnt_2;
    logic [CW-1:0]         inc_1, inc_2;

    press_latch u_latch_1 (
        .clk     (clk_i),
        .reset   (reset_i),
        .shoot   (player_1_shoot_i),
        .tick    (frame_tick_i),
        .keep    (keep_1),
        .pending (pend_1)
    );

    press_latch u_latch_2 (
        .clk     (clk_i),
        .reset   (reset_i),
        .shoot   (player_2_shoot_i),
        .tick    (frame_tick_i),
        .keep    (keep_2),
        .pending (pend_2)
    );

    // Lowest-index free slot, taken from the registered occupancy so a slot
    // released in the tick cycle is not handed out in that same cycle.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (!any_free && !slot_busy_o[k]) begin
                any_free = 1'b1;
                free_idx = IW'(k);
            end
        end
    end

    // Only slots that are actually occupied can be released.
    always_comb begin
        rel_mask  = slot_release_i & slot_busy_o;
        rel_cnt_1 = '0;
        rel_cnt_2 = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (rel_mask[k]) begin
                if (slot_owner_o[k]) begin
                    rel_cnt_2 = rel_cnt_2 + CW'(1);
                end else begin
                    rel_cnt_1 = rel_cnt_1 + CW'(1);
                end
            end
        end
    end

    always_comb begin
        elig_1  = pend_1 && (cd_1 == '0) && (p1_active_o < MAX_CNT) && any_free;
        elig_2  = pend_2 && (cd_2 == '0) && (p2_active_o < MAX_CNT) && any_free;
        contend = elig_1 && elig_2;
        grant   = frame_tick_i && (elig_1 || elig_2);

        if (contend) begin
            grant_player = prio;
        end else if (elig_1) begin
            grant_player = PLAYER_1;
        end else begin
            grant_player = PLAYER_2;
        end

        // The contention loser keeps its request; every other pending
        // request is consumed by the tick, granted or not.
        keep_1 = contend && (grant_player == PLAYER_2);
        keep_2 = contend && (grant_player == PLAYER_1);

        grant_mask = grant ? (NUM_SLOTS'(1) << free_idx) : '0;
        inc_1      = CW'(grant && (grant_player == PLAYER_1));
        inc_2      = CW'(grant && (grant_player == PLAYER_2));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            spawn_valid_o  <= 1'b0;
            spawn_player_o <= 1'b0;
            spawn_slot_o   <= '0;
            slot_busy_o    <= '0;
            slot_owner_o   <= '0;
            p1_active_o    <= '0;
            p2_active_o    <= '0;
            cd_1           <= '0;
            cd_2           <= '0;
            prio           <= PLAYER_1;
        end else begin
            spawn_valid_o  <= grant;
            spawn_player_o <= grant ? grant_player : 1'b0;
            spawn_slot_o   <= grant ? free_idx : '0;

            slot_busy_o  <= (slot_busy_o & ~rel_mask) | grant_mask;
            // Owner bits of freed slots are cleared so the field reads 0
            // wherever the slot is empty.
            slot_owner_o <= (slot_owner_o & ~rel_mask)
                          | (grant_player == PLAYER_2 ? grant_mask : '0);

            p1_active_o <= p1_active_o - rel_cnt_1 + inc_1;
            p2_active_o <= p2_active_o - rel_cnt_2 + inc_2;

            if (inc_1 != '0) begin
                cd_1 <= CD_LOAD;
            end else if (frame_tick_i && cd_1 != '0) begin
                cd_1 <= cd_1 - 1'b1;
            end

            if (inc_2 != '0) begin
                cd_2 <= CD_LOAD;
            end else if (frame_tick_i && cd_2 != '0) begin
                cd_2 <= cd_2 - 1'b1;
            end

            if (frame_tick_i && contend) begin
                prio <= (prio == PLAYER_1) ? PLAYER_2 : PLAYER_1;
            end
        end
    end

    assign p1_cooling_o = (cd_1 != '0);
    assign p2_cooling_o = (cd_2 != '0);

endmodule

// File: tb/tb_bullet_slot_arbiter.sv
// tb/tb_bullet_slot_arbiter.sv - self-checking bench for bullet_slot_arbiter
module tb_bullet_slot_arbiter;

    localparam int NS   = 4;
    localparam int MAXP = 2;
    localparam int CDF  = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          p1_shoot = 1'b0;
    logic          p2_shoot = 1'b0;
    logic          frame_tick = 1'b0;
    logic [NS-1:0] slot_release = '0;
    logic          spawn_valid;
    logic          spawn_player;
    logic [1:0]    spawn_slot;
    logic [NS-1:0] slot_busy;
    logic [NS-1:0] slot_owner;
    logic [2:0]    p1_active;
    logic [2:0]    p2_active;
    logic          p1_cooling;
    logic          p2_cooling;

    int n_cmp = 0;
    int n_bad = 0;

    bullet_slot_arbiter #(
        .NUM_SLOTS       (NS),
        .MAX_PER_PLAYER  (MAXP),
        .COOLDOWN_FRAMES (CDF)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .player_1_shoot_i (p1_shoot),
        .player_2_shoot_i (p2_shoot),
        .frame_tick_i     (frame_tick),
        .slot_release_i   (slot_release),
        .spawn_valid_o    (spawn_valid),
        .spawn_player_o   (spawn_player),
        .spawn_slot_o     (spawn_slot),
        .slot_busy_o      (slot_busy),
        .slot_owner_o     (slot_owner),
        .p1_active_o      (p1_active),
        .p2_active_o      (p2_active),
        .p1_cooling_o     (p1_cooling),
        .p2_cooling_o     (p2_cooling)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: slot table, per-player cooldown and request,
    // plus the contention priority. Counts are derived from the table.
    bit m_busy[NS];
    bit m_owner[NS];
    int m_cd[2];
    bit m_pend[2];
    bit m_prev[2];
    int m_prio;
    bit m_sv;
    int m_sp;
    int m_ss;
    bit started = 0;

    function automatic int m_count(input int p);
        int c = 0;
        for (int k = 0; k < NS; k++) if (m_busy[k] && m_owner[k] == p[0]) c++;
        return c;
    endfunction

    task automatic model_step();
        bit sh[2];
        bit el[2];
        int win;
        int fs;
        sh[0] = p1_shoot;
        sh[1] = p2_shoot;
        if (reset) begin
            for (int k = 0; k < NS; k++) begin m_busy[k] = 0; m_owner[k] = 0; end
            for (int p = 0; p < 2; p++) begin m_cd[p] = 0; m_pend[p] = 0; m_prev[p] = 0; end
            m_prio = 0; m_sv = 0; m_sp = 0; m_ss = 0;
            started = 1;
            return;
        end
        m_sv = 0; m_sp = 0; m_ss = 0;
        win = -1;
        fs = -1;
        if (frame_tick) begin
            for (int k = NS - 1; k >= 0; k--) if (!m_busy[k]) fs = k;
            for (int p = 0; p < 2; p++)
                el[p] = m_pend[p] && m_cd[p] == 0 && m_count(p) < MAXP && fs >= 0;
            if (el[0] && el[1]) begin win = m_prio; m_prio = 1 - m_prio; end
            else if (el[0]) win = 0;
            else if (el[1]) win = 1;
            for (int p = 0; p < 2; p++) begin
                if (m_cd[p] > 0) m_cd[p]--;
                if (!(el[0] && el[1] && p != win)) m_pend[p] = 0;
            end
        end
        for (int k = 0; k < NS; k++)
            if (slot_release[k] && m_busy[k]) begin m_busy[k] = 0; m_owner[k] = 0; end
        if (win >= 0) begin
            m_cd[win] = CDF;
            m_busy[fs] = 1;
            m_owner[fs] = win[0];
            m_sv = 1; m_sp = win; m_ss = fs;
        end
        for (int p = 0; p < 2; p++) begin
            if (sh[p] && !m_prev[p]) m_pend[p] = 1;
            m_prev[p] = sh[p];
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (started) begin
            int eb;
            int eo;
            eb = 0;
            eo = 0;
            for (int k = 0; k < NS; k++) begin
                if (m_busy[k]) eb |= (1 << k);
                if (m_owner[k]) eo |= (1 << k);
            end
            check("m_spawn_valid", int'(spawn_valid), int'(m_sv));
            check("m_spawn_player", int'(spawn_player), m_sp);
            check("m_spawn_slot", int'(spawn_slot), m_ss);
            check("m_slot_busy", int'(slot_busy), eb);
            check("m_slot_owner", int'(slot_owner), eo);
            check("m_p1_active", int'(p1_active), m_count(0));
            check("m_p2_active", int'(p2_active), m_count(1));
            check("m_p1_cooling", int'(p1_cooling), int'(m_cd[0] > 0));
            check("m_p2_cooling", int'(p2_cooling), int'(m_cd[1] > 0));
        end
    end

    task automatic do_tick();
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) do_tick();
    endtask

    task automatic press(input bit a, input bit b);
        @(negedge clk); p1_shoot = a; p2_shoot = b;
        @(negedge clk); p1_shoot = 1'b0; p2_shoot = 1'b0;
    endtask

    task automatic rel_pulse(input logic [NS-1:0] m);
        @(negedge clk); slot_release = m;
        @(negedge clk); slot_release = '0;
    endtask

    // After a tick: literal spawn expectation.
    task automatic expect_spawn(input string name, input int v, input int pl, input int sl);
        check({name, "_valid"}, int'(spawn_valid), v);
        if (v != 0) begin
            check({name, "_player"}, int'(spawn_player), pl);
            check({name, "_slot"}, int'(spawn_slot), sl);
        end
    endtask

    initial begin
        int nsp;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", int'(slot_busy), 0);
        check("rst_valid", int'(spawn_valid), 0);
        check("rst_p1_active", int'(p1_active), 0);

        // Single P1 shot and its cooldown window.
        press(1, 0);
        do_tick();
        expect_spawn("p1_first", 1, 0, 0);
        check("p1_first_busy", int'(slot_busy), 1);
        check("p1_first_active", int'(p1_active), 1);
        check("p1_first_cooling", int'(p1_cooling), 1);
        wait_ticks(14);
        check("p1_cool_14", int'(p1_cooling), 1);
        do_tick();
        check("p1_cool_15", int'(p1_cooling), 0);
        rel_pulse(4'b0001);
        check("rel_busy", int'(slot_busy), 0);
        check("rel_active", int'(p1_active), 0);

        // Simultaneous presses: P1 wins first, P2's request carries over.
        press(1, 1);
        do_tick();
        expect_spawn("both_t1", 1, 0, 0);
        do_tick();
        expect_spawn("both_t2", 1, 1, 1);
        check("both_owner", int'(slot_owner), 2);
        rel_pulse(4'b0011);
        wait_ticks(16);

        // Held button yields a single request.
        @(negedge clk); p1_shoot = 1'b1;
        nsp = 0;
        for (int i = 0; i < 20; i++) begin
            do_tick();
            if (spawn_valid) nsp++;
        end
        check("hold_spawns", nsp, 1);
        @(negedge clk); p1_shoot = 1'b0;
        rel_pulse(4'b0001);
        wait_ticks(2);

        // Per-player cap, dropped request, then reuse of a freed slot.
        press(1, 0); do_tick(); expect_spawn("cap_a", 1, 0, 0);
        wait_ticks(16);
        press(1, 0); do_tick(); expect_spawn("cap_b", 1, 0, 1);
        wait_ticks(16);
        press(1, 0); do_tick(); expect_spawn("cap_full", 0, 0, 0);
        check("cap_active", int'(p1_active), 2);
        rel_pulse(4'b0001);
        do_tick(); expect_spawn("cap_dropped", 0, 0, 0);
        press(1, 0); do_tick(); expect_spawn("cap_reuse", 1, 0, 0);

        // Full pool; a release on the tick cycle is not reusable that tick.
        press(0, 1); do_tick(); expect_spawn("p2_a", 1, 1, 2);
        wait_ticks(16);
        press(0, 1); do_tick(); expect_spawn("p2_b", 1, 1, 3);
        check("full_busy", int'(slot_busy), 15);
        check("full_sum", int'(p1_active) + int'(p2_active), 4);
        wait_ticks(16);
        press(0, 1);
        @(negedge clk); frame_tick = 1'b1; slot_release = 4'b0100;
        @(negedge clk); frame_tick = 1'b0; slot_release = '0;
        expect_spawn("full_tick", 0, 0, 0);
        check("full_after_rel", int'(slot_busy), 11);
        press(0, 1); do_tick(); expect_spawn("full_refill", 1, 1, 2);

        // Reset right after a granting tick.
        rel_pulse(4'b1111);
        wait_ticks(16);
        press(1, 0); do_tick(); expect_spawn("pre_rst", 1, 0, 0);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("post_rst_valid", int'(spawn_valid), 0);
        check("post_rst_busy", int'(slot_busy), 0);
        check("post_rst_active", int'(p1_active), 0);
        check("post_rst_cool", int'(p1_cooling), 0);

        // Reset on the tick cycle itself suppresses the pending spawn.
        press(1, 0);
        @(negedge clk); frame_tick = 1'b1; reset = 1'b1;
        @(negedge clk); frame_tick = 1'b0; reset = 1'b0;
        check("rst_tick_valid", int'(spawn_valid), 0);
        check("rst_tick_busy", int'(slot_busy), 0);
        do_tick();
        check("rst_tick_nopend", int'(spawn_valid), 0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
